// File: rtl/sram_access_ctrl.sv
// Burst initiator for a single-port synchronous SRAM with registered dout.
// Write beats stream straight to the array; read beats return through a 2-entry buffer.
module sram_access_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int LEN_WIDTH  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_we,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    output logic                  ram_en,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;
    logic                  inflight_q, inflight_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  wptr_q, rptr_q;
    logic [DATA_WIDTH-1:0] buf_q [2];

    logic       cmd_fire;
    logic       wr_fire;
    logic       issue;
    logic       push;
    logic       pop_buf;
    logic       rd_fire;
    logic       last;
    logic       drained;
    logic [1:0] occ;

    assign cmd_fire = cmd_valid & cmd_ready;
    assign wr_fire  = wr_valid & wr_ready;
    assign last     = (rem_q == '0);
    assign occ      = cnt_q + {1'b0, inflight_q};
    assign issue    = (state_q == READ) && (occ < 2'd2);

    // An empty buffer lets returning SRAM data flow straight to the client.
    assign rd_valid = (cnt_q != 2'd0) | inflight_q;
    assign rd_fire  = rd_valid & rd_ready;
    assign pop_buf  = (cnt_q != 2'd0) & rd_ready;
    assign push     = inflight_q & ~((cnt_q == 2'd0) & rd_ready);
    assign drained  = (occ == 2'd0) | ((occ == 2'd1) & rd_fire);

    assign rd_data  = (cnt_q != 2'd0) ? buf_q[rptr_q] :
                      inflight_q      ? ram_dout      : '0;
    assign ram_addr = addr_q;
    assign busy     = (state_q != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (cmd_fire) state_d = cmd_we ? WRITE : READ;
            WRITE:   if (wr_fire && last) state_d = IDLE;
            READ:    if (issue && last) state_d = DRAIN;
            DRAIN:   if (drained) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = 1'b0;
        wr_ready  = 1'b0;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_din   = '0;
        unique case (state_q)
            IDLE: cmd_ready = ~rst;
            WRITE: begin
                wr_ready = 1'b1;
                ram_en   = wr_valid;
                ram_we   = wr_valid;
                ram_din  = wr_data;
            end
            READ:    ram_en = issue;
            default: ;
        endcase
    end

    always_comb begin
        addr_d     = addr_q;
        rem_d      = rem_q;
        inflight_d = issue;
        cnt_d      = cnt_q + {1'b0, push} - {1'b0, pop_buf};
        if (cmd_fire) begin
            addr_d = cmd_addr;
            rem_d  = cmd_len;
        end else if (wr_fire || issue) begin
            addr_d = addr_q + ADDR_WIDTH'(1);
            rem_d  = rem_q - LEN_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q     <= '0;
            rem_q      <= '0;
            inflight_q <= 1'b0;
            cnt_q      <= 2'd0;
            wptr_q     <= 1'b0;
            rptr_q     <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            inflight_q <= inflight_d;
            cnt_q      <= cnt_d;
            if (push) begin
                wptr_q <= ~wptr_q;
            end
            if (pop_buf) begin
                rptr_q <= ~rptr_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_q[wptr_q] <= ram_dout;
        end
    end

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Directed bench for sram_access_ctrl with an SRAM model and a burst-level
// reference (shadow memory plus expected address/data queues).
module tb_sram_access_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid, cmd_ready, cmd_we;
    logic [2:0] cmd_addr, cmd_len;
    logic       wr_valid, wr_ready;
    logic [7:0] wr_data;
    logic       rd_valid, rd_ready;
    logic [7:0] rd_data;
    logic       busy;
    logic [2:0] ram_addr;
    logic [7:0] ram_din;
    logic       ram_en, ram_we;
    logic [7:0] ram_dout = 8'h00;
    logic [7:0] mem [8] = '{default: 8'h00};

    sram_access_ctrl #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(3),
        .LEN_WIDTH (3)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .busy(busy),
        .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_en(ram_en), .ram_we(ram_we), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_din;
            else        ram_dout <= mem[ram_addr];
        end
    end

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int mode = 0;
    int wleft = 0;
    int rleft = 0;
    int outst = 0;
    int acc_cyc = 0;
    int first_valid = -1;
    logic acc, wacc;
    logic [2:0] wa_cur;
    logic [7:0] shadow [8];
    logic [2:0] raddr_q [$];
    logic [7:0] rdat_q [$];
    logic [2:0] wlog [$];
    logic [7:0] plog [$];
    int         pcyc [$];
    logic [7:0] stim [$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic step();
        logic [2:0] a;
        @(negedge clk);
        cyc++;
        acc = 1'b0;
        wacc = 1'b0;
        if (rst) begin
            chk("rst_ctrl", {cmd_ready, wr_ready, rd_valid,
                             busy, ram_en, ram_we}, 0);
            chk("rst_data", {ram_addr, ram_din, rd_data}, 0);
        end else begin
            chk("cmd_ready", cmd_ready, mode == 0);
            chk("busy", busy, mode != 0);
            chk("wr_ready", wr_ready, mode == 1);
            chk("ram_we", ram_we, mode == 1 && wr_valid);
            if (mode != 2) chk("ram_en", ram_en, mode == 1 && wr_valid);
            if (outst == 0) chk("rd_valid_empty", rd_valid, 0);
            if (mode == 1 && wr_valid) begin
                chk("wr_addr", ram_addr, wa_cur);
                chk("wr_din", ram_din, wr_data);
                shadow[wa_cur] = wr_data;
                wlog.push_back(ram_addr);
                wa_cur = wa_cur + 3'd1;
                wacc = 1'b1;
                wleft--;
                if (wleft == 0) mode = 0;
            end
            if (mode == 2 && ram_en && !ram_we) begin
                chk("issue_room", outst < 2, 1);
                if (raddr_q.size() == 0) chk("spurious_issue", ram_en, 0);
                else chk("rd_addr", ram_addr, raddr_q.pop_front());
                outst++;
            end
            if (rd_valid && first_valid < 0) first_valid = cyc;
            if (rd_valid && rd_ready) begin
                if (rdat_q.size() == 0) chk("spurious_beat", rd_valid, 0);
                else chk("rd_data", rd_data, rdat_q.pop_front());
                plog.push_back(rd_data);
                pcyc.push_back(cyc);
                outst--;
                rleft--;
                if (rleft == 0) mode = 0;
            end
            if (cmd_valid && mode == 0) begin
                acc = 1'b1;
                acc_cyc = cyc;
                if (cmd_we) begin
                    mode = 1;
                    wleft = int'(cmd_len) + 1;
                    wa_cur = cmd_addr;
                end else begin
                    mode = 2;
                    rleft = int'(cmd_len) + 1;
                    for (int i = 0; i <= int'(cmd_len); i++) begin
                        a = cmd_addr + 3'(i);
                        raddr_q.push_back(a);
                        rdat_q.push_back(shadow[a]);
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic we, input logic [2:0] a,
                            input logic [2:0] l);
        logic got;
        got = 1'b0;
        cmd_valid = 1'b1;
        cmd_we = we;
        cmd_addr = a;
        cmd_len = l;
        for (int n = 0; n < 20 && !got; n++) begin
            step();
            got = acc;
        end
        cmd_valid = 1'b0;
        if (!got) chk("cmd_timeout", got, 1);
    endtask

    task automatic write_burst(input logic [2:0] a, input logic [2:0] l,
                               input bit stall);
        int k;
        int n;
        wlog.delete();
        send_cmd(1'b1, a, l);
        k = 0;
        n = 0;
        while (k <= int'(l) && n < 50) begin
            wr_valid = stall ? (n % 2 == 1) : 1'b1;
            wr_data = stim[k];
            step();
            if (wacc) k++;
            n++;
        end
        wr_valid = 1'b0;
        if (k <= int'(l)) chk("wr_timeout", k, int'(l) + 1);
    endtask

    task automatic read_burst(input logic [2:0] a, input logic [2:0] l,
                              input bit pat);
        int n;
        plog.delete();
        pcyc.delete();
        first_valid = -1;
        rd_ready = 1'b1;
        send_cmd(1'b0, a, l);
        n = 0;
        while (mode != 0 && n < 100) begin
            rd_ready = pat ? (n % 3 == 0) : 1'b1;
            step();
            n++;
        end
        rd_ready = 1'b1;
        if (mode != 0) chk("rd_timeout", mode, 0);
    endtask

    logic [2:0] ea [4];
    logic [7:0] ed [8];

    initial begin
        for (int i = 0; i < 8; i++) shadow[i] = 8'h00;
        cmd_valid = 1'b0;
        cmd_we = 1'b0;
        cmd_addr = 3'd0;
        cmd_len = 3'd0;
        wr_valid = 1'b0;
        wr_data = 8'h00;
        rd_ready = 1'b0;

        repeat (2) step();
        rst = 1'b0;
        step();
        chk("post_rst_ready", cmd_ready, 1);

        stim = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        write_burst(3'd2, 3'd3, 1'b0);
        ea = '{3'd2, 3'd3, 3'd4, 3'd5};
        chk("t1_beats", wlog.size(), 4);
        for (int i = 0; i < 4 && i < wlog.size(); i++)
            chk("t1_addr", wlog[i], ea[i]);
        chk("t1_ready_after", cmd_ready, 1);
        step();

        read_burst(3'd2, 3'd3, 1'b0);
        chk("t2_latency", first_valid - acc_cyc, 2);
        chk("t2_beats", plog.size(), 4);
        ed = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 0, 0, 0, 0};
        for (int i = 0; i < 4 && i < plog.size(); i++)
            chk("t2_data", plog[i], ed[i]);
        if (pcyc.size() == 4) chk("t2_full_rate", pcyc[3] - pcyc[0], 3);
        chk("t2_busy_fall", busy, 0);

        stim = '{8'h11, 8'h22, 8'h33, 8'h44};
        write_burst(3'd6, 3'd3, 1'b0);
        ea = '{3'd6, 3'd7, 3'd0, 3'd1};
        chk("t3_beats", wlog.size(), 4);
        for (int i = 0; i < 4 && i < wlog.size(); i++)
            chk("t3_addr", wlog[i], ea[i]);
        read_burst(3'd6, 3'd3, 1'b0);
        ed = '{8'h11, 8'h22, 8'h33, 8'h44, 0, 0, 0, 0};
        chk("t3_rd_beats", plog.size(), 4);
        for (int i = 0; i < 4 && i < plog.size(); i++)
            chk("t3_data", plog[i], ed[i]);

        read_burst(3'd0, 3'd7, 1'b1);
        ed = '{8'h33, 8'h44, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'h11, 8'h22};
        chk("t4_beats", plog.size(), 8);
        for (int i = 0; i < 8 && i < plog.size(); i++)
            chk("t4_data", plog[i], ed[i]);

        stim = '{8'h55, 8'h66, 8'h77, 8'h88};
        write_burst(3'd4, 3'd3, 1'b1);
        ea = '{3'd4, 3'd5, 3'd6, 3'd7};
        chk("t5_beats", wlog.size(), 4);
        for (int i = 0; i < 4 && i < wlog.size(); i++)
            chk("t5_addr", wlog[i], ea[i]);
        step();
        read_burst(3'd4, 3'd3, 1'b0);
        ed = '{8'h55, 8'h66, 8'h77, 8'h88, 0, 0, 0, 0};
        for (int i = 0; i < 4 && i < plog.size(); i++)
            chk("t5_data", plog[i], ed[i]);

        plog.delete();
        rd_ready = 1'b1;
        send_cmd(1'b0, 3'd0, 3'd7);
        for (int n = 0; n < 20 && plog.size() < 2; n++) step();
        chk("t6_two_beats", plog.size(), 2);
        #2 rst = 1'b1;
        #1;
        chk("t6_async_ctrl", {cmd_ready, wr_ready, rd_valid,
                              busy, ram_en, ram_we}, 0);
        chk("t6_async_data", {ram_addr, ram_din, rd_data}, 0);
        mode = 0;
        outst = 0;
        rleft = 0;
        raddr_q.delete();
        rdat_q.delete();
        repeat (2) step();
        rst = 1'b0;
        step();
        chk("t6_ready", cmd_ready, 1);
        read_burst(3'd1, 3'd2, 1'b0);
        ed = '{8'h44, 8'hA0, 8'hA1, 0, 0, 0, 0, 0};
        chk("t6_beats", plog.size(), 3);
        for (int i = 0; i < 3 && i < plog.size(); i++)
            chk("t6_data", plog[i], ed[i]);
        step();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
